// File: rtl/sram_read_serializer.sv
// Burst reader: fetches 32-bit SRAM words and streams them out as
// bytes, LSB lane first, over a valid/ready handshake.
module sram_read_serializer #(
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [CNT_WIDTH-1:0]  word_count,
   output logic                  sram_re,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [31:0]           sram_rdata,
   output logic [7:0]            byte_out,
   output logic [1:0]            byte_sel,
   output logic                  byte_valid,
   input  logic                  byte_ready,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CAPTURE,
      SEND
   } state_t;

   state_t                state_q, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
   logic [CNT_WIDTH-1:0]  rem_q, rem_nx;
   logic [31:0]           word_q, word_nx;
   logic [1:0]            lane_q, lane_nx;
   logic                  done_q, done_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         word_q  <= '0;
         lane_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nx;
         addr_q  <= addr_nx;
         rem_q   <= rem_nx;
         word_q  <= word_nx;
         lane_q  <= lane_nx;
         done_q  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      addr_nx  = addr_q;
      rem_nx   = rem_q;
      word_nx  = word_q;
      lane_nx  = lane_q;
      done_nx  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (word_count != '0) begin
                  addr_nx  = start_addr;
                  rem_nx   = word_count;
                  state_nx = READ;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         READ: state_nx = CAPTURE;
         CAPTURE: begin
            word_nx  = sram_rdata;
            lane_nx  = 2'd0;
            state_nx = SEND;
         end
         SEND: begin
            if (byte_ready) begin
               if (lane_q != 2'd3) begin
                  lane_nx = lane_q + 2'd1;
               end else if (rem_q != CNT_WIDTH'(1)) begin
                  // address wraps naturally at 2^ADDR_WIDTH
                  rem_nx   = rem_q - CNT_WIDTH'(1);
                  addr_nx  = addr_q + ADDR_WIDTH'(1);
                  state_nx = READ;
               end else begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // addr_q only changes on entry to READ, so it holds while sram_re=0
   assign sram_re    = (state_q == READ);
   assign sram_addr  = addr_q;
   assign byte_valid = (state_q == SEND);
   assign byte_sel   = lane_q;
   assign byte_out   = word_q[8*lane_q +: 8];
   assign busy       = (state_q != IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_sram_read_serializer.sv
// Directed bench for sram_read_serializer with a one-cycle-latency
// SRAM model, read-address log and done-pulse counter.
module tb_sram_read_serializer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  start_addr;
   logic [7:0]  word_count;
   logic        sram_re;
   logic [7:0]  sram_addr;
   logic [31:0] sram_rdata;
   logic [7:0]  byte_out;
   logic [1:0]  byte_sel;
   logic        byte_valid;
   logic        byte_ready;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   logic [7:0]  re_log[$];
   logic [31:0] mem[256];

   sram_read_serializer #(
      .ADDR_WIDTH(8),
      .CNT_WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .start_addr(start_addr),
      .word_count(word_count),
      .sram_re   (sram_re),
      .sram_addr (sram_addr),
      .sram_rdata(sram_rdata),
      .byte_out  (byte_out),
      .byte_sel  (byte_sel),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      sram_rdata <= mem[sram_addr];
      if (sram_re) re_log.push_back(sram_addr);
      if (done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_byte(input logic [7:0] b, input logic [1:0] s);
      chk("byte_valid", 32'(byte_valid), 32'd1);
      chk("byte_out", 32'(byte_out), 32'(b));
      chk("byte_sel", 32'(byte_sel), 32'(s));
      tick();
   endtask

   task automatic go(input logic [7:0] a, input logic [7:0] n);
      start      = 1'b1;
      start_addr = a;
      word_count = n;
      tick();
      start = 1'b0;
   endtask

   int d0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hDDCCBBAA;
      mem[8'hFF] = 32'h44332211;
      mem[8'h00] = 32'h88776655;
      mem[8'h20] = 32'h04030201;
      mem[8'h50] = 32'h0C0B0A09;
      mem[8'h51] = 32'h100F0E0D;
      mem[8'h60] = 32'hEEEEEEEE;
      mem[8'h70] = 32'hA4A3A2A1;
      sram_rdata = 32'h0;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = 8'h0;
      word_count = 8'h0;
      byte_ready = 1'b1;
      tick();
      tick();
      chk("rst sram_re", 32'(sram_re), 0);
      chk("rst sram_addr", 32'(sram_addr), 0);
      chk("rst byte_out", 32'(byte_out), 0);
      chk("rst byte_sel", 32'(byte_sel), 0);
      chk("rst byte_valid", 32'(byte_valid), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      rst = 1'b0;
      tick();

      // single word
      re_log.delete();
      d0 = done_cnt;
      go(8'h10, 8'd1);
      chk("t1 re", 32'(sram_re), 1);
      chk("t1 addr", 32'(sram_addr), 32'h10);
      chk("t1 busy", 32'(busy), 1);
      tick();
      chk("t1 cap re", 32'(sram_re), 0);
      chk("t1 cap valid", 32'(byte_valid), 0);
      tick();
      exp_byte(8'hAA, 2'd0);
      exp_byte(8'hBB, 2'd1);
      exp_byte(8'hCC, 2'd2);
      exp_byte(8'hDD, 2'd3);
      chk("t1 done", 32'(done), 1);
      chk("t1 idle busy", 32'(busy), 0);
      chk("t1 idle valid", 32'(byte_valid), 0);
      tick();
      chk("t1 done low", 32'(done), 0);
      chk("t1 reads", 32'(re_log.size()), 1);
      chk("t1 dones", 32'(done_cnt - d0), 1);

      // two words wrapping 0xFF -> 0x00
      re_log.delete();
      d0 = done_cnt;
      go(8'hFF, 8'd2);
      chk("t2 addr0", 32'(sram_addr), 32'hFF);
      chk("t2 re0", 32'(sram_re), 1);
      tick();
      tick();
      exp_byte(8'h11, 2'd0);
      exp_byte(8'h22, 2'd1);
      exp_byte(8'h33, 2'd2);
      exp_byte(8'h44, 2'd3);
      chk("t2 re1", 32'(sram_re), 1);
      chk("t2 addr1", 32'(sram_addr), 32'h00);
      chk("t2 mid done", 32'(done), 0);
      tick();
      tick();
      exp_byte(8'h55, 2'd0);
      exp_byte(8'h66, 2'd1);
      exp_byte(8'h77, 2'd2);
      exp_byte(8'h88, 2'd3);
      chk("t2 done", 32'(done), 1);
      tick();
      tick();
      chk("t2 dones", 32'(done_cnt - d0), 1);
      chk("t2 reads", 32'(re_log.size()), 2);

      // backpressure on lane 2
      d0 = done_cnt;
      go(8'h20, 8'd1);
      tick();
      tick();
      exp_byte(8'h01, 2'd0);
      exp_byte(8'h02, 2'd1);
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3 hold valid", 32'(byte_valid), 1);
         chk("t3 hold out", 32'(byte_out), 32'h03);
         chk("t3 hold sel", 32'(byte_sel), 2);
      end
      byte_ready = 1'b1;
      exp_byte(8'h03, 2'd2);
      exp_byte(8'h04, 2'd3);
      chk("t3 done", 32'(done), 1);
      tick();
      chk("t3 dones", 32'(done_cnt - d0), 1);

      // zero count
      re_log.delete();
      d0 = done_cnt;
      go(8'h40, 8'd0);
      chk("t4 busy", 32'(busy), 0);
      chk("t4 re", 32'(sram_re), 0);
      chk("t4 done", 32'(done), 1);
      tick();
      chk("t4 done low", 32'(done), 0);
      chk("t4 busy2", 32'(busy), 0);
      chk("t4 reads", 32'(re_log.size()), 0);
      chk("t4 dones", 32'(done_cnt - d0), 1);

      // start while busy is ignored
      re_log.delete();
      go(8'h50, 8'd2);
      chk("t5 addr0", 32'(sram_addr), 32'h50);
      tick();
      start      = 1'b1;
      start_addr = 8'h60;
      word_count = 8'd1;
      tick();
      start = 1'b0;
      exp_byte(8'h09, 2'd0);
      start = 1'b1;
      exp_byte(8'h0A, 2'd1);
      start = 1'b0;
      exp_byte(8'h0B, 2'd2);
      exp_byte(8'h0C, 2'd3);
      chk("t5 addr1", 32'(sram_addr), 32'h51);
      tick();
      tick();
      exp_byte(8'h0D, 2'd0);
      exp_byte(8'h0E, 2'd1);
      exp_byte(8'h0F, 2'd2);
      exp_byte(8'h10, 2'd3);
      chk("t5 done", 32'(done), 1);
      tick();
      chk("t5 reads", 32'(re_log.size()), 2);
      if (re_log.size() == 2) begin
         chk("t5 log0", 32'(re_log[0]), 32'h50);
         chk("t5 log1", 32'(re_log[1]), 32'h51);
      end

      // reset during lane 1, with a colliding start
      d0 = done_cnt;
      go(8'h70, 8'd2);
      tick();
      tick();
      exp_byte(8'hA1, 2'd0);
      chk("t6 lane1", 32'(byte_sel), 1);
      rst        = 1'b1;
      start      = 1'b1;
      start_addr = 8'h10;
      word_count = 8'd1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk("t6 re", 32'(sram_re), 0);
      chk("t6 addr", 32'(sram_addr), 0);
      chk("t6 out", 32'(byte_out), 0);
      chk("t6 sel", 32'(byte_sel), 0);
      chk("t6 valid", 32'(byte_valid), 0);
      chk("t6 busy", 32'(busy), 0);
      chk("t6 done", 32'(done), 0);
      tick();
      tick();
      tick();
      chk("t6 idle", 32'(busy), 0);
      chk("t6 no done", 32'(done_cnt - d0), 0);
      go(8'h10, 8'd1);
      chk("t6 re new", 32'(sram_re), 1);
      chk("t6 addr new", 32'(sram_addr), 32'h10);
      tick();
      tick();
      exp_byte(8'hAA, 2'd0);
      exp_byte(8'hBB, 2'd1);
      exp_byte(8'hCC, 2'd2);
      exp_byte(8'hDD, 2'd3);
      chk("t6 done new", 32'(done), 1);
      tick();
      chk("t6 dones", 32'(done_cnt - d0), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_read_serializer.md
SRAM_READ_SERIALIZER -- requirements
Module: sram_read_serializer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: SRAM word-address width.
REQ-002 Parameter CNT_WIDTH, default 8: width of the word-count request field.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a burst read; sampled only in IDLE.
REQ-007 start_addr  input  ADDR_WIDTH  first SRAM word address of the burst.
REQ-008 word_count  input  CNT_WIDTH  number of 32-bit words to read.
REQ-009 sram_re  output  1  SRAM read enable.
REQ-010 sram_addr  output  ADDR_WIDTH  SRAM read address.
REQ-011 sram_rdata  input  32  SRAM read data, valid exactly one cycle after sram_re.
REQ-012 byte_out  output  8  serialized byte.
REQ-013 byte_sel  output  2  byte lane of byte_out within its word.
REQ-014 byte_valid  output  1  byte_out/byte_sel valid.
REQ-015 byte_ready  input  1  consumer accepts the byte; a transfer occurs when byte_valid and byte_ready are both high.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPTURE and SEND.
REQ-019 IDLE: start=1 with word_count!=0 SHALL latch start_addr into the address register and word_count into the remaining counter, then go to READ.
REQ-020 IDLE: start=1 with word_count=0 SHALL stay in IDLE, issue no SRAM read, and pulse done in the next cycle.
REQ-021 READ: sram_re=1 and sram_addr=current address for exactly one cycle, then go to CAPTURE.
REQ-022 CAPTURE: sram_rdata SHALL be registered into the word buffer, lane SHALL be set to 0, then go to SEND.
REQ-023 SEND: byte_valid=1, byte_sel=lane, byte_out=word[8*lane+7:8*lane]; lane 0 = bits [7:0] through lane 3 = bits [31:24], LSB lane first.
REQ-024 SEND, transfer with lane<3: lane SHALL increment and the state SHALL remain SEND.
REQ-025 SEND, transfer with lane=3 and remaining>1: remaining SHALL decrement, the address SHALL increment modulo 2^ADDR_WIDTH (all-ones wraps to 0), and the state SHALL go to READ.
REQ-026 SEND, transfer with lane=3 and remaining=1: the state SHALL go to IDLE and done SHALL be 1 in the following cycle.
REQ-027 While byte_valid=1 and byte_ready=0, byte_out and byte_sel SHALL hold stable and the state SHALL not change.
REQ-028 start while busy=1 SHALL be ignored, with no effect on the current burst.
REQ-029 Minimum latency: start to first byte_valid = 3 cycles; steady-state throughput with byte_ready held at 1 = 6 cycles per word.
REQ-030 sram_re SHALL be 0 in every state except READ; byte_valid SHALL be 0 in every state except SEND.
REQ-031 sram_addr SHALL hold its last value whenever sram_re=0.

Reset
REQ-032 When rst=1 at a clock edge, the FSM SHALL enter IDLE and the following SHALL all be 0: sram_re, sram_addr, byte_out, byte_sel, byte_valid, busy, done, lane, remaining counter and word buffer.
REQ-033 Reset mid-burst SHALL abandon the burst with no done pulse; rst SHALL take priority over start in the same cycle.

Verification
REQ-034 Single word: start, start_addr=0x10, word_count=1, sram_rdata=0xDDCCBBAA, byte_ready=1 -> one sram_re at addr 0x10; bytes 0xAA,0xBB,0xCC,0xDD with byte_sel 0,1,2,3; done pulses 1 cycle after the last transfer.
REQ-035 Burst with wrap: start_addr=0xFF, word_count=2 -> reads at addr 0xFF then 0x00; 8 bytes in order; exactly one done pulse.
REQ-036 Backpressure: byte_ready held at 0 for 5 cycles during lane 2 -> byte_out and byte_sel=2 stay stable; no lane advance; sequence resumes correctly once byte_ready=1.
REQ-037 Zero count: start with word_count=0 -> no sram_re, busy stays 0, done pulses the next cycle.
REQ-038 Start while busy: second start issued mid-burst with different start_addr -> ignored; only the original addresses are read.
REQ-039 Reset mid-burst: rst asserted during SEND lane 1 -> next cycle all outputs are 0, state IDLE, no done pulse; a new start after that runs normally.
